// File: rtl/nibble_add_sequencer.sv
// Multi-cycle wide add/subtract controller: one 4-bit adder is stepped across
// NIBBLES slices, LSB first, with the carry chained through a register.

module parallel_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] S,
  output logic       Co
);

  assign {Co, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Ci};

endmodule

module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [IDXW-1:0] index;
  logic [W-1:0]    a_reg, b_reg, work_reg, work_next;
  logic            sub_reg, carry_reg;

  logic [3:0] adder_a, adder_b, adder_s;
  logic       adder_co;
  logic       last_nibble;

  assign last_nibble = (index == IDXW'(NIBBLES - 1));

  // Subtraction is A + ~B + 1: B is inverted per slice and the chain starts at carry 1.
  always_comb begin
    adder_a   = a_reg[{index, 2'b00} +: 4];
    adder_b   = b_reg[{index, 2'b00} +: 4] ^ {4{sub_reg}};
    work_next = work_reg;
    work_next[{index, 2'b00} +: 4] = adder_s;
  end

  parallel_adder u_adder (
    .A  (adder_a),
    .B  (adder_b),
    .Ci (carry_reg),
    .S  (adder_s),
    .Co (adder_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_nibble) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Result outputs change only on the final slice so they are never seen half-built.
  always_ff @(posedge clk) begin
    if (rst) begin
      index     <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      work_reg  <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            sub_reg   <= sub;
            carry_reg <= sub;
            index     <= '0;
          end
        end
        RUN: begin
          work_reg  <= work_next;
          carry_reg <= adder_co;
          index     <= index + IDXW'(1);
          if (last_nibble) begin
            sum       <= work_next;
            carry_out <= adder_co;
            overflow  <= (a_reg[W-1] == (b_reg[W-1] ^ sub_reg)) &&
                         (adder_s[3] != a_reg[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer: a vector table for arithmetic and
// exact handshake timing, plus hand sequences for reset, ignored inputs and back-to-back.

module tb_nibble_add_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] sum;

  int n_applied    = 0;
  int n_miscompare = 0;
  int cyc          = 0;

  vec_t vecs[11];
  vec_t bb[3];

  nibble_add_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompare++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept one operation, scramble the inputs during RUN, and check exact timing.
  task automatic applyStimulus(input vec_t v);
    op_a  = v.a;
    op_b  = v.b;
    sub   = v.sub;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a  = ~v.a;
    op_b  = ~v.b;
    sub   = ~v.sub;
    for (int i = 0; i < NIBBLES; i++) begin
      checkOutput("busy_run", 32'(busy), 32'd1);
      checkOutput("done_early", 32'(done), 32'd0);
      tick();
    end
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    checkOutput("sum", 32'(sum), 32'(v.sum));
    checkOutput("carry_out", 32'(carry_out), 32'(v.cout));
    checkOutput("overflow", 32'(overflow), 32'(v.ovf));
    tick();
    checkOutput("done_cleared", 32'(done), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int done_count;
    int n;
    int done_cyc[3];
    vec_t v;

    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[10] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

    bb[0] = '{16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0};
    bb[1] = '{16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0};
    bb[2] = '{16'hF00F, 16'h0FF1, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    tick();
    tick();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_carry", 32'(carry_out), 32'd0);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);

    // Reset and start together: reset wins.
    op_a  = 16'h1111;
    op_b  = 16'h1111;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst_start_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("rst_start_busy2", 32'(busy), 32'd0);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    // Inputs and start changing during RUN have no effect.
    op_a  = 16'h0010;
    op_b  = 16'h0020;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a  = 16'hFFFF;
    op_b  = 16'hFFFF;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    done_count = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) done_count++;
      tick();
    end
    checkOutput("ignored_done_count", 32'(done_count), 32'd1);
    checkOutput("ignored_sum", 32'(sum), 32'h0030);
    checkOutput("ignored_busy", 32'(busy), 32'd0);
    tick();
    tick();
    checkOutput("sum_held", 32'(sum), 32'h0030);

    // Reset on the second RUN edge aborts without a done pulse.
    op_a  = 16'h1111;
    op_b  = 16'h2222;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    done_count = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) done_count++;
      tick();
    end
    checkOutput("abort_no_done", 32'(done_count), 32'd0);
    v = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    applyStimulus(v);

    // Back-to-back with start held high: one accept every NIBBLES+2 cycles.
    op_a  = bb[0].a;
    op_b  = bb[0].b;
    sub   = bb[0].sub;
    start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n = 0;
      tick();
      while (!done && n < 20) begin
        tick();
        n++;
      end
      done_cyc[j] = cyc;
      checkOutput("b2b_done_seen", 32'(done), 32'd1);
      checkOutput("b2b_sum", 32'(sum), 32'(bb[j].sum));
      checkOutput("b2b_carry", 32'(carry_out), 32'(bb[j].cout));
      if (j < 2) begin
        op_a = bb[j+1].a;
        op_b = bb[j+1].b;
        sub  = bb[j+1].sub;
      end else begin
        start = 1'b0;
      end
    end
    checkOutput("b2b_spacing1", 32'(done_cyc[1] - done_cyc[0]), 32'(NIBBLES + 2));
    checkOutput("b2b_spacing2", 32'(done_cyc[2] - done_cyc[1]), 32'(NIBBLES + 2));
    tick();
    tick();
    checkOutput("b2b_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
